pipe_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the enable and bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It runs a request/acknowledge handshake with a variable-latency data memory and freezes the pipeline while an access is outstanding. It also detects load-use hazards between the EX and ID stages and inserts one bubble.

---
 rtl/riscv_pipe_pkg.sv | 13 +
 rtl/load_use_detect.sv | 19 +
 rtl/pipe_stall_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared types and widths for the pipeline stall/flush sequencer.
package riscv_pipe_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int STALL_CNT_W = 16;

  // IDLE: no data-memory access outstanding; WAIT: frozen until the memory acks
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the EX-stage load and the ID-stage sources.
// Register x0 never carries a dependency, so a zero destination is ignored.
module load_use_detect
  import riscv_pipe_pkg::*;
(
  input  logic                  memtoreg_ex,
  input  logic [REG_ADDR_W-1:0] rd_addr_ex,
  input  logic [REG_ADDR_W-1:0] rs1_addr_id,
  input  logic [REG_ADDR_W-1:0] rs2_addr_id,
  output logic                  hazard
);

  // Flag a hazard when the EX load writes a register the ID instruction reads
  always_comb begin
    hazard = memtoreg_ex && (rd_addr_ex != '0) &&
             ((rd_addr_ex == rs1_addr_id) || (rd_addr_ex == rs2_addr_id));
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Freezes the pipe while a data-memory access is outstanding and inserts a
// single bubble on load-use hazards. A memory stall masks the hazard.
// Optional feature macro: MEM_TIMEOUT_EN (aborts accesses that wait too long).
module pipe_stall_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MemRead_mem,
  input  logic                   MemWrite_mem,
  input  logic                   MemtoReg_ex,
  input  logic [REG_ADDR_W-1:0]  rdAddr_ex,
  input  logic [REG_ADDR_W-1:0]  rs1Addr_id,
  input  logic [REG_ADDR_W-1:0]  rs2Addr_id,
  output logic                   dmem_req,
  input  logic                   dmem_ack,
  output logic                   stall_if,
  output logic                   stall_id,
  output logic                   stall_ex,
  output logic                   flush_ex,
  output logic                   hold_mem,
  output logic                   bubble_wb,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  pipe_state_e            state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   acc;
  logic                   hazard;
  logic                   mem_stall;
  logic                   tmo_hit;

  assign acc = MemRead_mem | MemWrite_mem;

  load_use_detect u_load_use_detect (
    .memtoreg_ex (MemtoReg_ex),
    .rd_addr_ex  (rdAddr_ex),
    .rs1_addr_id (rs1Addr_id),
    .rs2_addr_id (rs2Addr_id),
    .hazard      (hazard)
  );

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;

  // Terminal WAIT cycle with no ack: the access is dropped; an ack here still wins
  assign tmo_hit = (state_q == WAIT) && !dmem_ack &&
                   (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter and sticky abort flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Count WAIT cycles while staying in WAIT; anything else clears the counter
  always_comb begin
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q | tmo_hit;
    if ((state_q == WAIT) && (state_d == WAIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;
`else
  logic unused_cfg;

  assign tmo_hit     = 1'b0;
  assign mem_timeout = 1'b0;
  assign unused_cfg  = (TIMEOUT_CYCLES > 0) ^ (CNT_W > 0);
`endif

  // A memory stall is any cycle an access is pending without its ack
  assign mem_stall = !rst &&
                     (((state_q == IDLE) && acc && !dmem_ack) ||
                      ((state_q == WAIT) && !dmem_ack && !tmo_hit));

  // State register and stall-cycle statistics counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic: enter WAIT on an unacked access, leave on ack or abort
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      IDLE: if (acc && !dmem_ack) state_d = WAIT;
      WAIT: if (dmem_ack || tmo_hit) state_d = IDLE;
    endcase
    if (mem_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Output logic: memory stall first, then the load-use bubble; all quiet in reset
  always_comb begin
    dmem_req  = 1'b0;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    flush_ex  = 1'b0;
    hold_mem  = 1'b0;
    bubble_wb = 1'b0;
    if (!rst) begin
      dmem_req = (state_q == WAIT) || acc;
      if (mem_stall) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        hold_mem  = 1'b1;
        bubble_wb = 1'b1;
      end else begin
        bubble_wb = tmo_hit;
        if (hazard) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
      end
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
// Honours MEM_TIMEOUT_EN the same way the design does.
module tb_pipe_stall_ctrl;

  localparam int TIMEOUT = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        mem_rd, mem_wr, m2r_ex, ack;
  logic [4:0]  rd_ex, rs1_id, rs2_id;
  logic        dmem_req, stall_if, stall_id, stall_ex, flush_ex;
  logic        hold_mem, bubble_wb, mem_timeout;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model: is an access outstanding, how long has it stalled so far
  bit m_busy    = 1'b0;
  int m_waited  = 0;
  int m_cnt     = 0;
  bit m_tmo     = 1'b0;
  bit m_stall   = 1'b0;
  bit m_tmo_hit = 1'b0;

  pipe_stall_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .MemRead_mem  (mem_rd),
    .MemWrite_mem (mem_wr),
    .MemtoReg_ex  (m2r_ex),
    .rdAddr_ex    (rd_ex),
    .rs1Addr_id   (rs1_id),
    .rs2Addr_id   (rs2_id),
    .dmem_req     (dmem_req),
    .dmem_ack     (ack),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .stall_ex     (stall_ex),
    .flush_ex     (flush_ex),
    .hold_mem     (hold_mem),
    .bubble_wb    (bubble_wb),
    .mem_timeout  (mem_timeout),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Derive this cycle's expected outputs from the current inputs and model
  task automatic checkOutput();
    bit acc, hz;
    bit e_req, e_if, e_id, e_ex, e_fl, e_hold, e_bub;
    acc       = mem_rd || mem_wr;
    hz        = m2r_ex && (rd_ex != 0) && ((rd_ex == rs1_id) || (rd_ex == rs2_id));
    m_tmo_hit = TMO_EN && m_busy && !ack && (m_waited >= TIMEOUT);
    m_stall   = m_busy ? (!ack && !m_tmo_hit) : (acc && !ack);
    if (rst) begin
      m_stall   = 1'b0;
      m_tmo_hit = 1'b0;
    end
    e_req  = !rst && (m_busy || acc);
    e_if   = !rst && (m_stall || hz);
    e_id   = e_if;
    e_ex   = m_stall;
    e_fl   = !rst && !m_stall && hz;
    e_hold = m_stall;
    e_bub  = m_stall || m_tmo_hit;
    check("dmem_req",    16'(dmem_req),    16'(e_req));
    check("stall_if",    16'(stall_if),    16'(e_if));
    check("stall_id",    16'(stall_id),    16'(e_id));
    check("stall_ex",    16'(stall_ex),    16'(e_ex));
    check("flush_ex",    16'(flush_ex),    16'(e_fl));
    check("hold_mem",    16'(hold_mem),    16'(e_hold));
    check("bubble_wb",   16'(bubble_wb),   16'(e_bub));
    check("mem_timeout", 16'(mem_timeout), 16'(m_tmo));
    check("stall_cnt",   stall_cnt,        16'(m_cnt));
  endtask

  // Advance the model across the clock edge
  task automatic updateModel();
    if (rst) begin
      m_busy   = 1'b0;
      m_waited = 0;
      m_cnt    = 0;
      m_tmo    = 1'b0;
    end else begin
      if (m_stall) begin
        m_busy   = 1'b1;
        m_waited = m_waited + 1;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else begin
        m_busy   = 1'b0;
        m_waited = 0;
      end
      if (m_tmo_hit) m_tmo = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, check mid-cycle, then step past the edge
  task automatic applyStimulus(input logic r, input logic rd, input logic wr,
                               input logic m2r, input logic [4:0] rde,
                               input logic [4:0] s1, input logic [4:0] s2,
                               input logic a);
    rst    = r;
    mem_rd = rd;
    mem_wr = wr;
    m2r_ex = m2r;
    rd_ex  = rde;
    rs1_id = s1;
    rs2_id = s2;
    ack    = a;
    #3;
    checkOutput();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; m2r_ex = 1'b0;
    rd_ex = '0; rs1_id = '0; rs2_id = '0; ack = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset with an access and a hazard present");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    check("reset_stall_cnt", stall_cnt, 16'd0);

    $display("[TB] zero-wait load");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idleCycle();
    check("zero_wait_cnt", stall_cnt, 16'd0);

    $display("[TB] store acked three cycles late");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idleCycle();
    check("store_wait3_cnt", stall_cnt, 16'd3);

    $display("[TB] load-use hazard on rs2, then rd = x0");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    idleCycle();

    $display("[TB] hazard held during a two-cycle memory wait");
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 5'd7, 5'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 5'd7, 5'd2, 1'b1);
    idleCycle();
    check("hazard_wait_cnt", stall_cnt, 16'd5);

    $display("[TB] reset in the middle of a wait, late ack afterwards");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    check("post_reset_cnt", stall_cnt, 16'd0);

    $display("[TB] long wait with no ack");
    for (int i = 0; i < TIMEOUT + 2; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    if (!TMO_EN) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idleCycle();
    idleCycle();
    check("long_wait_flag", 16'(mem_timeout), 16'(TMO_EN));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("flag_cleared", 16'(mem_timeout), 16'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 49) == 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
